// File: rtl/sp_sync_ram_large.sv
// Single-port synchronous RAM on a shared tristate data bus, one-cycle read latency.
// Define SPRAM_PARITY_EN to store a per-word even-parity bit and flag mismatches on read.
module sp_sync_ram_large #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe,
  output logic                  parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
`ifdef SPRAM_PARITY_EN
  localparam int unsigned WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_WIDTH = DATA_WIDTH;
`endif

  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  drive_en_c;
  logic [WORD_WIDTH-1:0] wr_word_c;
  logic [WORD_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] rd_q;

  // Storage starts cleared so unwritten locations read back as zero.
  logic [WORD_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  assign wr_en_c    = cs_input & we;
  assign rd_en_c    = cs_input & ~we;
  assign drive_en_c = rd_en_c & oe;
  assign rd_word_c  = mem[addr];

`ifdef SPRAM_PARITY_EN
  assign wr_word_c = {^data, data};
`else
  assign wr_word_c = data;
`endif

  // Array has no reset: writes land even while rst_n is low and contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[addr] <= wr_word_c;
    end
  end

  // Read register holds across writes and deselected cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en_c) begin
      rd_q <= rd_word_c[DATA_WIDTH-1:0];
    end
  end

`ifdef SPRAM_PARITY_EN
  logic perr_q;

  // Error flag tracks the read register: recomputed parity vs stored bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else if (rd_en_c) begin
      perr_q <= (^rd_word_c[DATA_WIDTH-1:0]) ^ rd_word_c[DATA_WIDTH];
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data = drive_en_c ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram_large.sv
// Bench for sp_sync_ram_large: associative-array memory model checked every negedge,
// plus directed literal expectations for writes, reads, bus release and reset.
module tb_sp_sync_ram_large;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        cs     = 1'b0;
  logic        we     = 1'b0;
  logic        oe     = 1'b0;
  logic        tb_drv = 1'b0;
  logic [13:0] addr   = '0;
  logic [15:0] wdata  = '0;
  wire  [15:0] data;
  logic        parity_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: memory contents, corrupted words, expected read register / flag.
  logic [15:0] model_mem [int];
  bit          corrupt   [int];
  logic [15:0] model_rd   = '0;
  bit          model_perr = 1'b0;

  assign data = tb_drv ? wdata : 16'bz;

  sp_sync_ram_large #(.ADDR_WIDTH(14), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .data       (data),
    .cs_input   (cs),
    .we         (we),
    .oe         (oe),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Released bus must not carry the (nonzero) read-register value.
  task automatic chk_rel(input string name);
    n_checks++;
    if (data === model_rd) begin
      n_fails++;
      $display("FAIL %s: got driven %h required Z at %0t", name, data, $time);
    end
  endtask

  // Model update on the active edge from the bench's own applied inputs.
  always @(posedge clk) begin : model_upd
    int a;
    a = int'(addr);
    if (cs && we) begin
      model_mem[a] = wdata;
      if (corrupt.exists(a)) corrupt.delete(a);
    end else if (cs && rst_n) begin
      model_rd   = model_mem.exists(a) ? model_mem[a] : 16'h0000;
      model_perr = corrupt.exists(a);
    end
  end

  always @(negedge rst_n) begin
    model_rd   = '0;
    model_perr = 1'b0;
  end

  // Compare process: runs on every falling edge.
  always @(negedge clk) begin
    if (!tb_drv) begin
      if (cs && oe && !we) chk("bus_read", data, model_rd);
      else if (model_rd != 16'h0000) chk_rel("bus_release");
    end
    chk("parity_err", {15'b0, parity_err}, {15'b0, model_perr});
  end

  task automatic op(input logic c, input logic w, input logic o,
                    input logic [13:0] a, input logic [15:0] d);
    @(posedge clk);
    #2;
    cs = c; we = w; oe = o; addr = a; wdata = d; tb_drv = w;
  endtask

  task automatic lit(input string name, input logic [15:0] exp);
    @(negedge clk);
    #1;
    chk(name, data, exp);
  endtask

  logic [15:0] vals [16] = '{16'h110C, 16'h210E, 16'h110D, 16'h310B, 16'h210D, 16'h110E,
                             16'h310F, 16'h210E, 16'h8400, 16'h9102, 16'h7000, 16'h0005,
                             16'h0007, 16'h0000, 16'h0000, 16'hFFFF};

  initial begin
    // Reset with clock running and a read requested.
    op(1'b1, 1'b0, 1'b1, 14'h0010, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h0010, 16'h0);
    lit("reset_rd_zero", 16'h0000);
    @(posedge clk); #2; rst_n = 1'b1;

    // Single write then read.
    op(1'b1, 1'b1, 1'b0, 14'h0100, 16'h110C);
    op(1'b1, 1'b0, 1'b1, 14'h0100, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h0100, 16'h0);
    lit("read_0x100", 16'h110C);

    // Burst write/read of 16 words at full throughput.
    for (int i = 0; i < 16; i++) op(1'b1, 1'b1, 1'b0, 14'(14'h0100 + i), vals[i]);
    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 1'b1, 14'(14'h0100 + i), 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h0108, 16'h0);
    lit("burst_last_0x10F", 16'hFFFF);
    op(1'b1, 1'b0, 1'b1, 14'h0108, 16'h0);
    lit("reread_0x108", 16'h8400);

    // Address boundaries.
    op(1'b1, 1'b1, 1'b0, 14'h0000, 16'h1357);
    op(1'b1, 1'b1, 1'b0, 14'h3FFF, 16'h2468);
    op(1'b1, 1'b0, 1'b1, 14'h0000, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h3FFF, 16'h0);
    lit("addr_min", 16'h1357);
    op(1'b1, 1'b0, 1'b1, 14'h3FFF, 16'h0);
    lit("addr_max", 16'h2468);

    // Deselected write is ignored; unwritten location reads zero.
    op(1'b0, 1'b1, 1'b0, 14'h0200, 16'hAAAA);
    op(1'b1, 1'b0, 1'b1, 14'h0200, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h0200, 16'h0);
    lit("cs0_write_ignored", 16'h0000);

    // Bus release with oe=0 / cs=0 while the read register holds 'hFFFF; hold across write.
    op(1'b1, 1'b0, 1'b1, 14'h010F, 16'h0);
    op(1'b1, 1'b0, 1'b0, 14'h010F, 16'h0);
    op(1'b0, 1'b0, 1'b1, 14'h0100, 16'h0);
    op(1'b1, 1'b1, 1'b0, 14'h0120, 16'h1111);
    op(1'b1, 1'b0, 1'b1, 14'h0120, 16'h0);
    lit("hold_over_cs0_and_write", 16'hFFFF);
    op(1'b1, 1'b0, 1'b1, 14'h0120, 16'h0);
    lit("read_after_write", 16'h1111);

    // Asynchronous reset mid-read, write during reset, recovery.
    op(1'b1, 1'b0, 1'b1, 14'h010F, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h010F, 16'h0);
    #1; rst_n = 1'b0;
    #1; chk("reset_async_zero", data, 16'h0000);
    op(1'b1, 1'b1, 1'b0, 14'h0400, 16'h1234);
    op(1'b1, 1'b0, 1'b1, 14'h010F, 16'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    op(1'b1, 1'b0, 1'b1, 14'h0400, 16'h0);
    lit("after_reset_0x10F", 16'hFFFF);
    op(1'b1, 1'b0, 1'b1, 14'h0400, 16'h0);
    lit("write_during_reset", 16'h1234);

`ifdef SPRAM_PARITY_EN
    // Corrupt one stored data bit behind the parity bit.
    op(1'b1, 1'b1, 1'b0, 14'h0300, 16'h0005);
    op(1'b1, 1'b1, 1'b0, 14'h0301, 16'h00F0);
    #1;
    dut.mem[14'h0300][0] = ~dut.mem[14'h0300][0];
    model_mem[32'h300] = 16'h0004;
    corrupt[32'h300] = 1'b1;
    op(1'b1, 1'b0, 1'b1, 14'h0300, 16'h0);
    op(1'b1, 1'b0, 1'b1, 14'h0301, 16'h0);
    lit("corrupt_data", 16'h0004);
    chk("corrupt_perr", {15'b0, parity_err}, 16'h0001);
    op(1'b1, 1'b0, 1'b1, 14'h0301, 16'h0);
    lit("clean_data", 16'h00F0);
    chk("clean_perr", {15'b0, parity_err}, 16'h0000);
`endif

    op(1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    op(1'b0, 1'b0, 1'b0, 14'h0000, 16'h0);
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sp_sync_ram_large.md
SP_SYNC_RAM_LARGE -- requirements
Module: sp_sync_ram_large

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter ADDR_WIDTH, default 14, SHALL set the word-address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter DATA_WIDTH, default 16, SHALL set the word width in bits.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Port addr, input, ADDR_WIDTH bits, SHALL be the word address.
REQ-007 Port data, inout, DATA_WIDTH bits, SHALL be the shared bidirectional data bus.
REQ-008 Port cs_input, input, 1 bit, SHALL be the active-high chip select.
REQ-009 Port we, input, 1 bit, SHALL be the active-high write enable.
REQ-010 Port oe, input, 1 bit, SHALL be the active-high output enable.
REQ-011 Port parity_err, output, 1 bit, SHALL be the registered read-parity error flag.

Function
REQ-012 Write: on a rising clk edge with cs_input=1 and we=1, mem[addr] SHALL take the value on data; oe is ignored for writes.
REQ-013 Read: on a rising clk edge with cs_input=1 and we=0, the read register SHALL load mem[addr].
REQ-014 Read latency SHALL be one cycle: an address sampled at edge N SHALL appear on data after edge N and be valid for capture at edge N+1.
REQ-015 data SHALL be driven with the read register only when cs_input=1, oe=1 and we=0; otherwise data SHALL be high-impedance.
REQ-016 During a write, or while cs_input=0, the read register SHALL hold its previous value.
REQ-017 A write and a read of the same address SHALL NOT occur in the same cycle (we selects one); a read in the cycle after a write to that address SHALL return the newly written value.
REQ-018 The addr range SHALL cover the full depth; there SHALL be no out-of-range case and no address wrap logic.
REQ-019 Memory contents SHALL initialise to all zeros at time zero, so an unwritten location SHALL read as 0.
REQ-020 Back-to-back writes or reads on consecutive cycles SHALL be supported at full throughput with no idle cycles.

Reset
REQ-021 While rst_n=0, the read register SHALL be 0 and parity_err SHALL be 0, independent of clk.
REQ-022 Reset SHALL NOT alter memory contents.
REQ-023 A reset asserted mid-read SHALL make the read register 0 immediately; the first read after rst_n rises SHALL follow REQ-013/014.
REQ-024 A write whose edge coincides with rst_n=0 SHALL still update memory.

Configuration
REQ-025 With macro SPRAM_PARITY_EN defined, each word SHALL store one extra even-parity bit computed on write.
REQ-026 With SPRAM_PARITY_EN defined, each read SHALL load parity_err with 1 when the recomputed parity of the stored word mismatches the stored parity bit, else 0; parity_err SHALL be updated in the same cycle as the read register.
REQ-027 Without SPRAM_PARITY_EN, the parity_err port SHALL remain present, be tied to 0, and no parity storage SHALL be inferred.

Verification
REQ-028 Write 'h110C to 'h100, then read 'h100 with oe=1 -> data='h110C one cycle after the address is sampled.
REQ-029 Write 'h100..'h10F with 'h110C,'h210E,'h110D,'h310B,'h210D,'h110E,'h310F,'h210E,'h8400,'h9102,'h7000,'h0005,'h0007,'h0000,'h0000,'hFFFF, then read all 16 -> each returned value equals the value written.
REQ-030 Write 'hAAAA to 'h200 with cs_input=0, then read 'h200 -> data=0; with oe=0 or cs_input=0 during a read cycle, data SHALL be Z.
REQ-031 Read 'h10F ('hFFFF), then pull rst_n low mid-cycle -> the read register and data drive SHALL be 0 immediately; after release, reading 'h10F returns 'hFFFF.
REQ-032 With SPRAM_PARITY_EN defined, write 'h0005, flip one stored data bit via backdoor, then read -> parity_err=1; an unmodified word read -> parity_err=0.
